// File: rtl/program_sequencer_pkg.sv
// Shared processor package for the program sequencer.
// Contents: the sequencer state enum (RUN/HALT), the instruction size in
// bytes, the default interrupt vector and a small width helper.
package program_sequencer_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } seq_state_t;

  localparam int unsigned INSTR_BYTES        = 2;
  localparam int unsigned DEFAULT_INT_VECTOR = 32'h0000_0010;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/program_sequencer_return_stack.sv
// return_stack: LIFO of return addresses for the program sequencer.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   i_en            advance enable; all state holds when low
//   i_push          push i_push_data (ignored while full)
//   i_pop           drop the top entry (ignored while empty)
//   i_push_data     address to push
//   o_top           current top entry (valid when !o_empty)
//   o_count         number of valid entries, 0..DEPTH
//   o_full, o_empty combinational from o_count
// Push takes precedence if both are asserted; the sequencer never does that.
module return_stack
  import program_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_push_data,
  output logic [WIDTH-1:0] o_top,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned IW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic [IW-1:0]    w_wr_idx;
  logic [IW-1:0]    w_top_idx;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_wr_idx  = r_count[IW-1:0];
  // count==DEPTH has zero low bits, so the wrap of -1 lands on DEPTH-1.
  assign w_top_idx = r_count[IW-1:0] - IW'(1);
  assign o_top     = r_mem[w_top_idx];

  assign w_do_push = i_en & i_push & ~o_full;
  assign w_do_pop  = i_en & i_pop & ~i_push & ~o_empty;

  always_ff @(posedge clk) begin
    if (reset)          r_count <= '0;
    else if (w_do_push) r_count <= r_count + CW'(1);
    else if (w_do_pop)  r_count <= r_count - CW'(1);
  end

  // Entries are not cleared on reset; a reset only abandons the write.
  always_ff @(posedge clk) begin
    if (!reset && w_do_push) r_mem[w_wr_idx] <= i_push_data;
  end

endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: next-PC selection with call/return stack and halt.
// Optional interrupt support compiled in with macro SEQ_INTERRUPT_EN.
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   clk_en                     advance enable (reset acts regardless)
//   branch_taken/_immediate    relative branch, signed word offset
//   jump_taken/_link/_immediate relative jump, optional return-address push
//   return_cmd                 pop return address into pc
//   halt_cmd                   enter HALT, pc holds
//   int_trigger                interrupt request (ignored unless compiled in)
//   pc, halted                 program counter, HALT state indicator
//   stack_*                    stack occupancy and sticky error flags
// Priority in RUN: interrupt, halt, return, jump, branch, sequential.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = 16,
  parameter int unsigned STACK_DEPTH  = 4,
  parameter int unsigned BR_IMM_WIDTH = 6,
  parameter int unsigned J_IMM_WIDTH  = 12,
  parameter int unsigned INT_VECTOR   = DEFAULT_INT_VECTOR
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clk_en,
  input  logic                           branch_taken,
  input  logic [BR_IMM_WIDTH-1:0]        branch_immediate,
  input  logic                           jump_taken,
  input  logic                           jump_link,
  input  logic [J_IMM_WIDTH-1:0]         jump_immediate,
  input  logic                           return_cmd,
  input  logic                           halt_cmd,
  input  logic                           int_trigger,
  output logic [PC_WIDTH-1:0]            pc,
  output logic                           halted,
  output logic                           stack_empty,
  output logic                           stack_full,
  output logic [$clog2(STACK_DEPTH):0]   stack_count,
  output logic                           stack_overflow,
  output logic                           stack_underflow
);

  localparam logic [PC_WIDTH-1:0] INT_VEC = INT_VECTOR[PC_WIDTH-1:0];
  localparam int unsigned BR_PAD = PC_WIDTH - BR_IMM_WIDTH - 1;
  localparam int unsigned J_PAD  = PC_WIDTH - J_IMM_WIDTH - 1;

  seq_state_t          r_state, w_next_state;
  logic [PC_WIDTH-1:0] r_pc, w_next_pc;
  logic                r_ovf, r_unf;

  logic [PC_WIDTH-1:0] w_seq, w_br_off, w_j_off, w_br_tgt, w_j_tgt;
  logic [PC_WIDTH-1:0] w_push_data, w_stk_top;
  logic                w_push_req, w_pop_req, w_set_ovf, w_set_unf;
  logic                w_stk_full, w_stk_empty;
  logic                w_int;

`ifdef SEQ_INTERRUPT_EN
  assign w_int = int_trigger;
`else
  logic w_unused_int;
  assign w_unused_int = int_trigger;
  assign w_int        = 1'b0;
`endif

  // Offsets are in words: sign-extend and shift left by one.
  assign w_br_off = {{BR_PAD{branch_immediate[BR_IMM_WIDTH-1]}}, branch_immediate, 1'b0};
  assign w_j_off  = {{J_PAD{jump_immediate[J_IMM_WIDTH-1]}}, jump_immediate, 1'b0};
  assign w_seq    = r_pc + PC_WIDTH'(INSTR_BYTES);
  assign w_br_tgt = w_seq + w_br_off;
  assign w_j_tgt  = w_seq + w_j_off;

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_push_req   = 1'b0;
    w_push_data  = w_seq;
    w_pop_req    = 1'b0;
    w_set_unf    = 1'b0;
    unique case (r_state)
      RUN: begin
        if (w_int) begin
          w_push_req = 1'b1;
          w_next_pc  = INT_VEC;
        end else if (halt_cmd) begin
          w_next_state = HALT;
        end else if (return_cmd) begin
          if (w_stk_empty) begin
            w_set_unf = 1'b1;
            w_next_pc = w_seq;
          end else begin
            w_pop_req = 1'b1;
            w_next_pc = w_stk_top;
          end
        end else if (jump_taken) begin
          w_push_req = jump_link;
          w_next_pc  = w_j_tgt;
        end else if (branch_taken) begin
          w_next_pc = w_br_tgt;
        end else begin
          w_next_pc = w_seq;
        end
      end
      HALT: begin
        // Only an interrupt leaves HALT; it resumes at the halted pc.
        if (w_int) begin
          w_push_req   = 1'b1;
          w_push_data  = r_pc;
          w_next_pc    = INT_VEC;
          w_next_state = RUN;
        end
      end
      default: w_next_state = RUN;
    endcase
  end

  // A push into a full stack is dropped by the stack; the jump still happens.
  assign w_set_ovf = w_push_req & w_stk_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_pc    <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (clk_en) begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_ovf   <= r_ovf | w_set_ovf;
      r_unf   <= r_unf | w_set_unf;
    end
  end

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (PC_WIDTH)
  ) u_stack (
    .clk         (clk),
    .reset       (reset),
    .i_en        (clk_en),
    .i_push      (w_push_req),
    .i_pop       (w_pop_req),
    .i_push_data (w_push_data),
    .o_top       (w_stk_top),
    .o_count     (stack_count),
    .o_full      (w_stk_full),
    .o_empty     (w_stk_empty)
  );

  assign pc              = r_pc;
  assign halted          = (r_state == HALT);
  assign stack_full      = w_stk_full;
  assign stack_empty     = w_stk_empty;
  assign stack_overflow  = r_ovf;
  assign stack_underflow = r_unf;

endmodule

// File: tb/tb_program_sequencer.sv
module tb_program_sequencer;

  logic        clk = 1'b0;
  logic        reset, clk_en, branch_taken, jump_taken, jump_link;
  logic        return_cmd, halt_cmd, int_trigger;
  logic [5:0]  branch_immediate;
  logic [11:0] jump_immediate;
  logic [15:0] pc;
  logic        halted, stack_empty, stack_full, stack_overflow, stack_underflow;
  logic [2:0]  stack_count;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Reference model state
  int unsigned m_pc;
  bit          m_halt, m_ovf, m_unf;
  int unsigned m_stk[$];

  program_sequencer dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .branch_taken(branch_taken), .branch_immediate(branch_immediate),
    .jump_taken(jump_taken), .jump_link(jump_link), .jump_immediate(jump_immediate),
    .return_cmd(return_cmd), .halt_cmd(halt_cmd), .int_trigger(int_trigger),
    .pc(pc), .halted(halted), .stack_empty(stack_empty), .stack_full(stack_full),
    .stack_count(stack_count), .stack_overflow(stack_overflow),
    .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic m_push(input int unsigned a);
    if (m_stk.size() == 4) m_ovf = 1'b1;
    else m_stk.push_back(a);
  endtask

  // Behavioural model: one architectural step per enabled clock edge.
  always @(posedge clk) begin : model
    int unsigned seq;
    int          off;
    bit          ion;
    if (reset) begin
      m_pc = 0; m_halt = 0; m_ovf = 0; m_unf = 0; m_stk.delete();
    end else if (clk_en) begin
`ifdef SEQ_INTERRUPT_EN
      ion = int_trigger;
`else
      ion = 1'b0;
`endif
      seq = (m_pc + 2) & 32'hFFFF;
      if (m_halt) begin
        if (ion) begin m_push(m_pc); m_pc = 32'h10; m_halt = 0; end
      end else if (ion) begin
        m_push(seq); m_pc = 32'h10;
      end else if (halt_cmd) begin
        m_halt = 1;
      end else if (return_cmd) begin
        if (m_stk.size() == 0) begin m_unf = 1; m_pc = seq; end
        else m_pc = m_stk.pop_back();
      end else if (jump_taken) begin
        off = $signed(jump_immediate);
        if (jump_link) m_push(seq);
        m_pc = (seq + off * 2) & 32'hFFFF;
      end else if (branch_taken) begin
        off = $signed(branch_immediate);
        m_pc = (seq + off * 2) & 32'hFFFF;
      end else begin
        m_pc = seq;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pc", 32'(pc), m_pc);
      chk("halted", 32'(halted), 32'(m_halt));
      chk("stack_count", 32'(stack_count), m_stk.size());
      chk("stack_empty", 32'(stack_empty), 32'(m_stk.size() == 0));
      chk("stack_full", 32'(stack_full), 32'(m_stk.size() == 4));
      chk("stack_overflow", 32'(stack_overflow), 32'(m_ovf));
      chk("stack_underflow", 32'(stack_underflow), 32'(m_unf));
    end
  end

  task automatic clr();
    reset = 0; clk_en = 1; branch_taken = 0; branch_immediate = '0;
    jump_taken = 0; jump_link = 0; jump_immediate = '0;
    return_cmd = 0; halt_cmd = 0; int_trigger = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    clr();
  endtask

  task automatic do_reset();
    clr(); reset = 1; tick();
  endtask

  task automatic jmp(input logic [11:0] imm, input logic link);
    jump_taken = 1; jump_link = link; jump_immediate = imm; tick();
  endtask

  initial begin
    clr();
    reset = 1;
    tick();
    cmp_en = 1'b1;
    chk("rst_pc", 32'(pc), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_empty", 32'(stack_empty), 1);
    chk("rst_full", 32'(stack_full), 0);
    chk("rst_count", 32'(stack_count), 0);
    chk("rst_flags", {30'd0, stack_overflow, stack_underflow}, 0);

    // Sequential advance and clock-enable hold
    tick(); chk("seq_pc2", 32'(pc), 2);
    tick(); chk("seq_pc4", 32'(pc), 4);
    tick(); chk("seq_pc6", 32'(pc), 6);
    clk_en = 0; tick(); chk("hold_pc6", 32'(pc), 6);
    chk("model_hold_pc6", m_pc, 6);

    // Branch backwards, then wrap at the top of the address space
    do_reset();
    jmp(12'd7, 0); chk("jmp_to_10", 32'(pc), 32'h10);
    branch_taken = 1; branch_immediate = 6'h3E; tick();
    chk("branch_neg", 32'(pc), 32'h0E);
    do_reset();
    jmp(12'hFFE, 0); chk("jmp_to_fffe", 32'(pc), 32'hFFFE);
    tick(); chk("wrap_pc0", 32'(pc), 0);

    // Linked jump and return
    do_reset();
    jmp(12'd15, 0); chk("jmp_to_20", 32'(pc), 32'h20);
    jmp(12'h010, 1); chk("jal_pc", 32'(pc), 32'h42);
    chk("jal_count", 32'(stack_count), 1);
    return_cmd = 1; tick();
    chk("ret_pc", 32'(pc), 32'h22);
    chk("ret_empty", 32'(stack_empty), 1);

    // Overflow on the fifth push, underflow on the fifth pop
    do_reset();
    for (int i = 0; i < 4; i++) jmp(12'd0, 1);
    chk("full4", 32'(stack_full), 1);
    chk("no_ovf_yet", 32'(stack_overflow), 0);
    jmp(12'd0, 1);
    chk("ovf_set", 32'(stack_overflow), 1);
    chk("ovf_count", 32'(stack_count), 4);
    chk("ovf_pc", 32'(pc), 32'h0A);
    for (int i = 0; i < 4; i++) begin
      return_cmd = 1; tick();
      chk("pop_pc", 32'(pc), 32'(8 - 2 * i));
    end
    chk("no_unf_yet", 32'(stack_underflow), 0);
    return_cmd = 1; tick();
    chk("unf_set", 32'(stack_underflow), 1);
    chk("unf_pc_seq", 32'(pc), 4);
    chk("ovf_sticky", 32'(stack_overflow), 1);

    // Halt wins over branch; later commands ignored; reset recovers
    do_reset();
    tick(); tick();
    halt_cmd = 1; branch_taken = 1; branch_immediate = 6'h05; tick();
    chk("halt_set", 32'(halted), 1);
    chk("halt_pc", 32'(pc), 4);
    branch_taken = 1; branch_immediate = 6'h05; jump_taken = 1; jump_link = 1; tick();
    return_cmd = 1; tick();
    chk("halt_pc_held", 32'(pc), 4);
    chk("halt_no_push", 32'(stack_count), 0);
    do_reset();
    chk("halt_rst_pc", 32'(pc), 0);
    chk("halt_rst_flag", 32'(halted), 0);

    // Interrupt out of HALT
    jmp(12'd23, 0); chk("jmp_to_30", 32'(pc), 32'h30);
    halt_cmd = 1; tick();
    int_trigger = 1; tick();
`ifdef SEQ_INTERRUPT_EN
    chk("int_pc", 32'(pc), 32'h10);
    chk("int_run", 32'(halted), 0);
    chk("int_count", 32'(stack_count), 1);
    return_cmd = 1; tick();
    chk("int_ret_pc", 32'(pc), 32'h30);
`else
    chk("noint_halted", 32'(halted), 1);
    chk("noint_pc", 32'(pc), 32'h30);
    chk("noint_count", 32'(stack_count), 0);
`endif

    // Randomized traffic checked every cycle by the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      reset            = ($urandom_range(99) < 2);
      clk_en           = ($urandom_range(9) != 0);
      branch_taken     = ($urandom_range(3) == 0);
      branch_immediate = 6'($urandom);
      jump_taken       = ($urandom_range(4) == 0);
      jump_link        = $urandom_range(1) == 1;
      jump_immediate   = 12'($urandom);
      return_cmd       = ($urandom_range(4) == 0);
      halt_cmd         = ($urandom_range(29) == 0);
      int_trigger      = ($urandom_range(19) == 0);
      @(posedge clk); #1;
    end
    clr();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
